// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - operand/result bundle between ex stage, ctrl, regs and the M-extension unit
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      rd_addr_i;
    logic            reg_wen_i;
    logic            flush_i;
    logic [XLEN-1:0] rd_data_o;
    logic [4:0]      rd_addr_o;
    logic            reg_wen_o;
    logic            hold_flag_o;
    logic            busy_o;

    modport slave (
        input  valid_i, funct3_i, op1_i, op2_i, rd_addr_i, reg_wen_i, flush_i,
        output rd_data_o, rd_addr_o, reg_wen_o, hold_flag_o, busy_o
    );

    modport master (
        output valid_i, funct3_i, op1_i, op2_i, rd_addr_i, reg_wen_i, flush_i,
        input  rd_data_o, rd_addr_o, reg_wen_o, hold_flag_o, busy_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - bit-serial RV M-extension multiply/divide unit (shift-add, restoring divide)
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic              wen_q;
    logic              neg_q;     // product / quotient must be negated
    logic              neg_r;     // remainder must be negated
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   mcand;     // multiplicand magnitude
    logic [2*XLEN-1:0] acc;       // {partial product, multiplier bits not yet consumed}
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   quot;      // dividend bits shift out the top, quotient bits shift in
    logic [XLEN-1:0]   rem;

    logic              accept, sgn1, sgn2, s1, s2, div_zero, div_ovf, last;
    logic [XLEN-1:0]   abs1, abs2, quot_fix, rem_fix, sel_val;
    logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
    logic [2*XLEN-1:0] prod_fix;

    // Operand sign handling: MULH/DIV/REM are signed on both sides, MULHSU only on rs1.
    assign sgn1 = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) ||
                  (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
    assign sgn2 = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b100) ||
                  (bus.funct3_i == 3'b110);
    assign s1   = sgn1 & bus.op1_i[XLEN-1];
    assign s2   = sgn2 & bus.op2_i[XLEN-1];
    assign abs1 = s1 ? ({XLEN{1'b0}} - bus.op1_i) : bus.op1_i;
    assign abs2 = s2 ? ({XLEN{1'b0}} - bus.op2_i) : bus.op2_i;

    assign accept   = (state == IDLE) && bus.valid_i && !bus.flush_i;
    assign div_zero = bus.funct3_i[2] && (bus.op2_i == {XLEN{1'b0}});
    assign div_ovf  = bus.funct3_i[2] && !bus.funct3_i[0] &&
                      (bus.op1_i == MIN_NEG) && (&bus.op2_i);
    assign last     = (cnt == CNT_W'(1));

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mcand : {XLEN{1'b0}})};
    assign rem_shift = {rem, quot[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, divisor};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and stall request.
    always_comb begin
        state_nxt       = state;
        bus.hold_flag_o = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    bus.hold_flag_o = 1'b1;
                    if (!bus.funct3_i[2])          state_nxt = MUL;
                    else if (div_zero || div_ovf)  state_nxt = DONE;
                    else                           state_nxt = DIV;
                end
            end
            MUL, DIV: begin
                bus.hold_flag_o = 1'b1;
                if (bus.flush_i) state_nxt = IDLE;
                else if (last)   state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and one multiply/divide step per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            funct3_q <= 3'b000;
            rd_q     <= 5'd0;
            wen_q    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            mcand    <= '0;
            acc      <= '0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= bus.funct3_i;
                        rd_q     <= bus.rd_addr_i;
                        wen_q    <= bus.reg_wen_i;
                        cnt      <= CNT_W'(XLEN);
                        mcand    <= abs1;
                        acc      <= {{XLEN{1'b0}}, abs2};
                        divisor  <= abs2;
                        quot     <= abs1;
                        rem      <= '0;
                        neg_q    <= s1 ^ s2;
                        neg_r    <= s1;
                        // Short-cut results are architecturally fixed and never re-signed.
                        if (div_zero) begin
                            quot  <= '1;
                            rem   <= bus.op1_i;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end else if (div_ovf) begin
                            quot  <= bus.op1_i;
                            rem   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[XLEN-1:1]};
                    cnt <= cnt - CNT_W'(1);
                end
                DIV: begin
                    if (!rem_diff[XLEN]) begin
                        rem  <= rem_diff[XLEN-1:0];
                        quot <= {quot[XLEN-2:0], 1'b1};
                    end else begin
                        rem  <= rem_shift[XLEN-1:0];
                        quot <= {quot[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // The full double-width product is negated so the high half carries correctly.
    assign prod_fix = neg_q ? ({(2*XLEN){1'b0}} - acc) : acc;
    assign quot_fix = neg_q ? ({XLEN{1'b0}} - quot) : quot;
    assign rem_fix  = neg_r ? ({XLEN{1'b0}} - rem) : rem;

    // Result select by operation.
    always_comb begin
        sel_val = '0;
        case (funct3_q)
            3'b000:                 sel_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: sel_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         sel_val = quot_fix;
            default:                sel_val = rem_fix;
        endcase
    end

    assign bus.rd_data_o = (state == DONE) ? sel_val : '0;
    assign bus.rd_addr_o = (state == DONE) ? rd_q : 5'd0;
    assign bus.reg_wen_o = (state == DONE) && wen_q && !bus.flush_i;
    assign bus.busy_o    = (state != IDLE);
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv at XLEN 32 and 16
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_muldiv_if #(.XLEN(32)) bus();
    ex_muldiv_if #(.XLEN(16)) bus16();

    ex_muldiv #(.XLEN(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
    ex_muldiv #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        int          due;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
    } vec_t;

    exp_t sbq[$];
    exp_t cmp_e;
    int   pres_cyc;
    logic hold_first;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference results straight from the RV M-extension definition, for any width up to 32.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input int xl);
        longint unsigned mask, ua, ub;
        longint sa, sb, mn, r;
        logic ovf;
        mask = (64'd1 << xl) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ua[xl-1] ? (longint'(ua) - (longint'(1) << xl)) : longint'(ua);
        sb   = ub[xl-1] ? (longint'(ub) - (longint'(1) << xl)) : longint'(ub);
        mn   = -(longint'(1) << (xl - 1));
        ovf  = (sa == mn) && (sb == -1);
        case (f)
            3'd0:    r = longint'(ua * ub);
            3'd1:    r = (sa * sb) >>> xl;
            3'd2:    r = (sa * longint'(ub)) >>> xl;
            3'd3:    r = longint'((ua * ub) >> xl);
            3'd4:    r = (ub == 0) ? -1 : (ovf ? sa : sa / sb);
            3'd5:    r = (ub == 0) ? -1 : longint'(ua / ub);
            3'd6:    r = (ub == 0) ? sa : (ovf ? 0 : sa % sb);
            default: r = (ub == 0) ? longint'(ua) : longint'(ua % ub);
        endcase
        return 32'(r & longint'(mask));
    endfunction

    function automatic bit is_short(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b, input int xl);
        logic [31:0] mask, mn;
        mask = (xl == 32) ? 32'hFFFF_FFFF : ((32'd1 << xl) - 32'd1);
        mn   = 32'd1 << (xl - 1);
        return f[2] && (((b & mask) == 0) || (!f[0] && ((a & mask) == mn) && ((b & mask) == mask)));
    endfunction

    // Write-back scoreboard: every cycle either the due result appears or the outputs are quiet.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_result: rd %0d data 0x%08h not written by cycle %0d", sbq[0].rd, sbq[0].data, sbq[0].due);
            void'(sbq.pop_front());
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            cmp_e = sbq.pop_front();
            check("wb_wen",  {31'd0, bus.reg_wen_o}, {31'd0, cmp_e.wen});
            check("wb_data", bus.rd_data_o, cmp_e.data);
            check("wb_addr", {27'd0, bus.rd_addr_o}, {27'd0, cmp_e.rd});
        end else begin
            check("quiet_wen",  {31'd0, bus.reg_wen_o}, 32'd0);
            check("quiet_data", bus.rd_data_o, 32'd0);
        end
    end

    task automatic present(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic wen);
        @(negedge clk);
        bus.valid_i   = 1'b1;
        bus.funct3_i  = f;
        bus.op1_i     = a;
        bus.op2_i     = b;
        bus.rd_addr_i = rd;
        bus.reg_wen_i = wen;
        pres_cyc      = cyc;
        #1 hold_first = bus.hold_flag_o;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input string name);
        exp_t e;
        int   lat, nh;
        bit   done;
        lat = is_short(v.f, v.a, v.b, 32) ? 1 : 33;
        present(v.f, v.a, v.b, v.rd, v.wen);
        e.data = model(v.f, v.a, v.b, 32);
        e.rd   = v.rd;
        e.wen  = v.wen;
        e.due  = pres_cyc + lat;
        sbq.push_back(e);
        nh   = hold_first ? 1 : 0;
        done = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.hold_flag_o) nh++;
            if (!bus.busy_o) begin
                done = 1;
                break;
            end
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_hold"}, 32'(nh), 32'(lat));
        check({name, "_consumed"}, 32'(sbq.size()), 32'd0);
    endtask

    task automatic run16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                         input string name);
        logic [31:0] m;
        logic [15:0] got;
        logic [4:0]  got_rd;
        int          lat, seen;
        m    = model(f, {16'd0, a}, {16'd0, b}, 16);
        lat  = is_short(f, {16'd0, a}, {16'd0, b}, 16) ? 1 : 17;
        seen = -1;
        got  = '0;
        got_rd = '0;
        @(negedge clk);
        bus16.valid_i   = 1'b1;
        bus16.funct3_i  = f;
        bus16.op1_i     = a;
        bus16.op2_i     = b;
        bus16.rd_addr_i = 5'd3;
        bus16.reg_wen_i = 1'b1;
        @(posedge clk);
        #1 bus16.valid_i = 1'b0;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (bus16.reg_wen_o) begin
                seen   = k;
                got    = bus16.rd_data_o;
                got_rd = bus16.rd_addr_o;
                break;
            end
        end
        check({name, "_data"}, {16'd0, got}, {16'd0, m[15:0]});
        check({name, "_lat"}, 32'(seen), 32'(lat));
        check({name, "_rd"}, {27'd0, got_rd}, 32'd3);
        @(negedge clk);
    endtask

    vec_t vecs[21] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  1'b1},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  1'b1},
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  1'b1},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  1'b1},
        '{3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 5'd9,  1'b1},
        '{3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 5'd10, 1'b1},
        '{3'd5, 32'd20,        32'd3,         5'd11, 1'b1},
        '{3'd7, 32'd20,        32'd3,         5'd12, 1'b1},
        '{3'd4, 32'h1234_5678, 32'h0000_0000, 5'd13, 1'b1},
        '{3'd6, 32'h1234_5678, 32'h0000_0000, 5'd14, 1'b1},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1},
        '{3'd5, 32'h1234_5678, 32'h0000_0000, 5'd17, 1'b1},
        '{3'd7, 32'h8765_4321, 32'h0000_0000, 5'd18, 1'b1},
        '{3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0,  1'b1},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd19, 1'b0},
        '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 1'b1},
        '{3'd6, 32'd100,       32'hFFFF_FFF9, 5'd21, 1'b1},
        '{3'd4, 32'd7,         32'd100,       5'd22, 1'b1},
        '{3'd5, 32'hFFFF_FFFF, 32'd1,         5'd23, 1'b1},
        '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 1'b1}
    };

    initial begin
        bus.valid_i = 1'b0; bus.funct3_i = '0; bus.op1_i = '0; bus.op2_i = '0;
        bus.rd_addr_i = '0; bus.reg_wen_i = 1'b0; bus.flush_i = 1'b0;
        bus16.valid_i = 1'b0; bus16.funct3_i = '0; bus16.op1_i = '0; bus16.op2_i = '0;
        bus16.rd_addr_i = '0; bus16.reg_wen_i = 1'b0; bus16.flush_i = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_hold", {31'd0, bus.hold_flag_o}, 32'd0);
        check("rst_wen",  {31'd0, bus.reg_wen_o}, 32'd0);
        check("rst_data", bus.rd_data_o, 32'd0);
        check("rst_addr", {27'd0, bus.rd_addr_o}, 32'd0);
        rst = 1'b1;

        check("pin_mul",      model(3'd0, 32'h7, 32'hFFFF_FFFD, 32), 32'hFFFF_FFEB);
        check("pin_mulhu",    model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 32'hFFFF_FFFE);
        check("pin_mulh",     model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 32'h0000_0000);
        check("pin_mulhsu",   model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 32'hFFFF_FFFF);
        check("pin_div",      model(3'd4, 32'hFFFF_FFEC, 32'd3, 32), 32'hFFFF_FFFA);
        check("pin_rem",      model(3'd6, 32'hFFFF_FFEC, 32'd3, 32), 32'hFFFF_FFFE);
        check("pin_divu",     model(3'd5, 32'd20, 32'd3, 32), 32'd6);
        check("pin_remu",     model(3'd7, 32'd20, 32'd3, 32), 32'd2);
        check("pin_div0",     model(3'd4, 32'h1234_5678, 32'd0, 32), 32'hFFFF_FFFF);
        check("pin_rem0",     model(3'd6, 32'h1234_5678, 32'd0, 32), 32'h1234_5678);
        check("pin_ovf_div",  model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32), 32'h8000_0000);
        check("pin_ovf_rem",  model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32), 32'h0000_0000);
        check("pin_mul16",    model(3'd0, 32'h7FFF, 32'h2, 16), 32'h0000_FFFE);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("op%0d", i));

        // flush alongside valid in IDLE blocks the accept
        @(negedge clk);
        bus.valid_i = 1'b1; bus.flush_i = 1'b1; bus.funct3_i = 3'd0;
        bus.op1_i = 32'd3; bus.op2_i = 32'd4; bus.rd_addr_i = 5'd1; bus.reg_wen_i = 1'b1;
        #1 check("idle_flush_hold", {31'd0, bus.hold_flag_o}, 32'd0);
        @(posedge clk);
        #1 begin bus.valid_i = 1'b0; bus.flush_i = 1'b0; end
        @(negedge clk);
        check("idle_flush_busy", {31'd0, bus.busy_o}, 32'd0);

        // flush in the tenth DIV cycle cancels without a write
        present(3'd4, 32'd1000, 32'd7, 5'd2, 1'b1);
        repeat (10) @(negedge clk);
        check("flush_busy_before", {31'd0, bus.busy_o}, 32'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush_busy_after", {31'd0, bus.busy_o}, 32'd0);
        bus.flush_i = 1'b0;
        repeat (40) @(negedge clk);
        run_op('{3'd5, 32'd1000, 32'd7, 5'd2, 1'b1}, "after_flush");

        // valid held through busy and DONE yields a single result
        @(negedge clk);
        bus.valid_i = 1'b1; bus.funct3_i = 3'd0; bus.op1_i = 32'd11; bus.op2_i = 32'd13;
        bus.rd_addr_i = 5'd4; bus.reg_wen_i = 1'b1;
        sbq.push_back('{32'd143, 5'd4, 1'b1, cyc + 33});
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.reg_wen_o) break;
        end
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("held_valid_busy", {31'd0, bus.busy_o}, 32'd0);
        check("held_valid_consumed", 32'(sbq.size()), 32'd0);

        // reset in the middle of a multiply
        present(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("mid_rst_hold", {31'd0, bus.hold_flag_o}, 32'd0);
        check("mid_rst_addr", {27'd0, bus.rd_addr_o}, 32'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        run_op('{3'd0, 32'd5, 32'd5, 5'd25, 1'b1}, "mul5x5");

        run16(3'd0, 16'h7FFF, 16'h0002, "w16_mul");
        run16(3'd3, 16'hFFFF, 16'hFFFF, "w16_mulhu");
        run16(3'd2, 16'hFFFF, 16'hFFFF, "w16_mulhsu");
        run16(3'd4, 16'hFFEC, 16'h0003, "w16_div");
        run16(3'd6, 16'hFFEC, 16'h0003, "w16_rem");
        run16(3'd4, 16'h1234, 16'h0000, "w16_div0");
        run16(3'd4, 16'h8000, 16'hFFFF, "w16_ovf");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
